// File: rtl/uart_dev.sv
// uart_dev: memory-mapped UART with one TX and one RX channel, 8N1 framing.
// Register map by PrAddr: 0 DATA, 1 STATUS, 2 CTRL, 3 DIVISOR.
// Optional build macro: UART_LOOPBACK_EN adds CTRL[2], which feeds the internal
// TX line into the RX synchronizer instead of the uart_rxd pin.
module uart_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PrAddr,
    input  logic        WE,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        InterruptRequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam logic [15:0] DivReset = 16'd433;
    localparam logic [15:0] DivMin   = 16'd3;

`ifdef UART_LOOPBACK_EN
    localparam logic LoopbackEn = 1'b1;
`else
    localparam logic LoopbackEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

    // Register file
    logic [2:0]  ctrl_q;
    logic [15:0] div_q;
    logic        rx_valid_q;
    logic        overrun_q;
    logic        frame_err_q;
    logic [7:0]  rx_data_q;

    // Transmitter
    logic        tx_busy_q;
    logic        tx_line_q;
    logic [8:0]  tx_shift_q;
    logic [3:0]  tx_bit_q;
    logic [15:0] tx_cnt_q;
    logic [15:0] tx_div_q;

    // Receiver
    logic        rx_src;
    logic        rx_sync1_q;
    logic        rx_sync2_q;
    logic        rx_prev_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic [15:0] rx_start_last;
    logic        rx_store;
    logic        rx_ferr;

    logic [15:0] div_eff;
    logic        wr_data, wr_status, wr_ctrl, wr_div;
    logic        unused_data_in;

    assign unused_data_in = ^DataIn[31:16];

    assign wr_data   = WE && (PrAddr == 2'd0);
    assign wr_status = WE && (PrAddr == 2'd1);
    assign wr_ctrl   = WE && (PrAddr == 2'd2);
    assign wr_div    = WE && (PrAddr == 2'd3);

    // Divisors below 3 are too short to sample reliably, so clamp.
    assign div_eff = (div_q < DivMin) ? DivMin : div_q;

    // Start bit is checked mid-bit: (div+1)>>1 cycles after the falling edge.
    assign rx_start_last = ({1'b0, rx_div_q[15:1]} + {15'd0, rx_div_q[0]}) - 16'd1;

    // CTRL and DIVISOR registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= 3'd0;
            div_q  <= DivReset;
        end else begin
            if (wr_ctrl) ctrl_q <= {DataIn[2] & LoopbackEn, DataIn[1:0]};
            if (wr_div)  div_q  <= DataIn[15:0];
        end
    end

    // Transmitter: loads the frame on a DATA write while idle, shifts one bit per period
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_busy_q  <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_shift_q <= 9'h1FF;
            tx_bit_q   <= 4'd0;
            tx_cnt_q   <= 16'd0;
            tx_div_q   <= DivMin;
        end else if (!tx_busy_q) begin
            if (wr_data) begin
                tx_busy_q  <= 1'b1;
                tx_line_q  <= 1'b0;
                tx_shift_q <= {1'b1, DataIn[7:0]};
                tx_bit_q   <= 4'd0;
                tx_cnt_q   <= 16'd0;
                tx_div_q   <= div_eff;
            end
        end else if (tx_cnt_q == tx_div_q) begin
            tx_cnt_q <= 16'd0;
            if (tx_bit_q == 4'd9) begin
                // End of stop bit
                tx_busy_q <= 1'b0;
                tx_line_q <= 1'b1;
            end else begin
                tx_bit_q   <= tx_bit_q + 4'd1;
                tx_line_q  <= tx_shift_q[0];
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
            end
        end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
        end
    end

    assign uart_txd = tx_line_q;

`ifdef UART_LOOPBACK_EN
    assign rx_src = ctrl_q[2] ? tx_line_q : uart_rxd;
`else
    assign rx_src = uart_rxd;
`endif

    // Two-stage synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= rx_src;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    // RX FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= StIdle;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_div_q   <= DivMin;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_div_q   <= rx_div_d;
        end
    end

    // RX FSM next state: start detect, mid-bit sampling, stop-bit verdict
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_div_d   = rx_div_q;
        rx_store   = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state_q)
            StIdle: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = StStart;
                    rx_cnt_d   = 16'd0;
                    rx_div_d   = div_eff;
                end
            end
            StStart: begin
                if (rx_cnt_q == rx_start_last) begin
                    rx_cnt_d = 16'd0;
                    rx_bit_d = 3'd0;
                    // A line back high at mid-start is a glitch, not a frame
                    rx_state_d = rx_sync2_q ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            StData: begin
                if (rx_cnt_q == rx_div_q) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = StStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (rx_cnt_q == rx_div_q) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = StIdle;
                    rx_store   = rx_sync2_q;
                    rx_ferr    = !rx_sync2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // STATUS flags and received byte; a store beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= 8'd0;
        end else begin
            if (rx_store) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end else if (wr_status && DataIn[0]) begin
                rx_valid_q <= 1'b0;
            end

            if (rx_store && rx_valid_q && !(wr_status && DataIn[0])) begin
                overrun_q <= 1'b1;
            end else if (wr_status && DataIn[2]) begin
                overrun_q <= 1'b0;
            end

            if (rx_ferr) begin
                frame_err_q <= 1'b1;
            end else if (wr_status && DataIn[3]) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    // Read mux: purely combinational, no side effects
    always_comb begin
        DataOut = 32'd0;
        unique case (PrAddr)
            2'd0: DataOut = {24'd0, rx_data_q};
            2'd1: DataOut = {28'd0, frame_err_q, overrun_q, tx_busy_q, rx_valid_q};
            2'd2: DataOut = {29'd0, ctrl_q};
            2'd3: DataOut = {16'd0, div_q};
            default: DataOut = 32'd0;
        endcase
    end

    assign InterruptRequest = (rx_valid_q & ctrl_q[0]) | (~tx_busy_q & ctrl_q[1]);

endmodule

// File: tb/tb_uart_dev.sv
// Self-checking bench for uart_dev: register table, TX/RX frames, randomized
// frames against a byte-level model, and reset/glitch corner cases.
module tb_uart_dev;

`ifdef UART_LOOPBACK_EN
    localparam logic [31:0] CtrlMask = 32'h7;
`else
    localparam logic [31:0] CtrlMask = 32'h3;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  PrAddr;
    logic        WE;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        InterruptRequest;
    logic        uart_rxd;
    logic        uart_txd;

    int tests;
    int fails;

    // Behavioural RX status model
    logic       m_valid, m_ovr, m_fe;
    logic [7:0] m_byte;

    typedef struct {
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t vecs[8];

    uart_dev dut (
        .clk             (clk),
        .reset           (reset),
        .PrAddr          (PrAddr),
        .WE              (WE),
        .DataIn          (DataIn),
        .DataOut         (DataOut),
        .InterruptRequest(InterruptRequest),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        PrAddr = a;
        DataIn = d;
        WE     = 1'b1;
        @(negedge clk);
        WE     = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        PrAddr = a;
        #1;
        check(name, DataOut, exp);
    endtask

    function automatic int eff_per(input int d);
        return (d < 3) ? 4 : d + 1;
    endfunction

    // Transmit one byte and check the line every cycle against the 8N1 frame
    task automatic tx_frame(input logic [7:0] b, input int per, input bit inject);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        wr(2'd0, {24'd0, b});
        for (int k = 0; k < 10 * per; k++) begin
            check($sformatf("tx_line_%02h_c%0d", b, k), {31'd0, uart_txd},
                  {31'd0, frame[k / per]});
            PrAddr = 2'd1;
            #1;
            check($sformatf("tx_busy_%02h_c%0d", b, k), {31'd0, DataOut[1]}, 32'd1);
            if (inject && k == 10) begin
                PrAddr = 2'd0;
                DataIn = 32'h000000FF;
                WE     = 1'b1;
            end
            @(negedge clk);
            WE = 1'b0;
        end
        chk_rd($sformatf("tx_done_%02h", b), 2'd1, {28'd0, m_fe, m_ovr, 1'b0, m_valid});
        for (int k = 0; k < 6; k++) begin
            check("tx_idle_high", {31'd0, uart_txd}, 32'd1);
            @(negedge clk);
        end
    endtask

    // Drive one frame on uart_rxd, then idle long enough for the stop verdict
    task automatic rx_send(input logic [7:0] b, input logic stop, input int per);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = frame[i];
            repeat (per) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (per + 4) @(negedge clk);
        if (stop) begin
            m_ovr   = m_ovr | m_valid;
            m_valid = 1'b1;
            m_byte  = b;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic m_clear(input logic [31:0] mask);
        wr(2'd1, mask);
        if (mask[0]) m_valid = 1'b0;
        if (mask[2]) m_ovr   = 1'b0;
        if (mask[3]) m_fe    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_fe    = 1'b0;
        m_byte  = 8'd0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        PrAddr = 2'd0;
        WE = 1'b0;
        DataIn = 32'd0;
        uart_rxd = 1'b1;
        reset = 1'b1;

        vecs[0] = '{2'd3, 32'h12345678, 2'd3, 32'h00005678, 1'b0, "div_upper_bits"};
        vecs[1] = '{2'd2, 32'hFFFFFFFF, 2'd2, CtrlMask,     1'b1, "ctrl_all_ones"};
        vecs[2] = '{2'd1, 32'hFFFFFFFF, 2'd1, 32'h00000000, 1'b1, "status_w1c_idle"};
        vecs[3] = '{2'd2, 32'h00000001, 2'd2, 32'h00000001, 1'b0, "ctrl_rx_irq_only"};
        vecs[4] = '{2'd2, 32'h00000002, 2'd0, 32'h00000000, 1'b1, "data_empty_txirq"};
        vecs[5] = '{2'd3, 32'h00000002, 2'd3, 32'h00000002, 1'b1, "div_below_min"};
        vecs[6] = '{2'd2, 32'h00000000, 2'd2, 32'h00000000, 1'b0, "ctrl_clear"};
        vecs[7] = '{2'd3, 32'hFFFF0003, 2'd3, 32'h00000003, 1'b0, "div_three"};

        repeat (3) @(negedge clk);
        do_reset();

        // Reset values
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_irq", {31'd0, InterruptRequest}, 32'd0);
        chk_rd("rst_status", 2'd1, 32'h0);
        chk_rd("rst_div", 2'd3, 32'h1B1);
        chk_rd("rst_ctrl", 2'd2, 32'h0);
        chk_rd("rst_data", 2'd0, 32'h0);

        // Register table
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            chk_rd(vecs[i].name, vecs[i].raddr, vecs[i].exp_rd);
            check({vecs[i].name, "_irq"}, {31'd0, InterruptRequest}, {31'd0, vecs[i].exp_irq});
        end

        // TX 0xA5 at DIVISOR=3 with an ignored write mid-frame
        tx_frame(8'hA5, 4, 1'b1);

        // RX 0x3C with rx IRQ enabled, then clear
        wr(2'd2, 32'h1);
        rx_send(8'h3C, 1'b1, 4);
        chk_rd("rx3c_status", 2'd1, 32'h1);
        chk_rd("rx3c_data", 2'd0, 32'h3C);
        check("rx3c_irq", {31'd0, InterruptRequest}, 32'd1);
        m_clear(32'h1);
        check("rx3c_irq_clr", {31'd0, InterruptRequest}, 32'd0);
        chk_rd("rx3c_status_clr", 2'd1, 32'h0);

        // Back-to-back frames without clearing -> overrun
        rx_send(8'h11, 1'b1, 4);
        rx_send(8'h22, 1'b1, 4);
        chk_rd("ovr_data", 2'd0, 32'h22);
        chk_rd("ovr_status", 2'd1, 32'h5);

        // Two-cycle low glitch is a false start
        uart_rxd = 1'b0;
        repeat (2) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (30) @(negedge clk);
        chk_rd("glitch_status", 2'd1, 32'h5);
        chk_rd("glitch_data", 2'd0, 32'h22);

        // Stop bit 0 -> frame error, rx_valid untouched
        m_clear(32'hD);
        rx_send(8'h77, 1'b0, 4);
        chk_rd("ferr_status", 2'd1, 32'h8);
        chk_rd("ferr_data", 2'd0, 32'h22);

        // Reset in the middle of a TX frame
        wr(2'd0, 32'h00);
        repeat (15) @(negedge clk);
        check("midtx_low", {31'd0, uart_txd}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midtx_rst_txd", {31'd0, uart_txd}, 32'd1);
        reset = 1'b0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_fe = 1'b0;
        chk_rd("midtx_rst_status", 2'd1, 32'h0);
        chk_rd("midtx_rst_div", 2'd3, 32'h1B1);
        repeat (10) begin
            @(negedge clk);
            check("midtx_stays_idle", {31'd0, uart_txd}, 32'd1);
        end

        // Randomized TX frames with small divisors
        for (int n = 0; n < 4; n++) begin
            int d;
            logic [7:0] b;
            d = $urandom_range(0, 6);
            b = 8'($urandom);
            wr(2'd3, d);
            tx_frame(b, eff_per(d), 1'b0);
        end

        // Randomized RX frames against the status model
        wr(2'd2, 32'h1);
        for (int n = 0; n < 12; n++) begin
            int d;
            logic [7:0] b;
            logic stop;
            d = $urandom_range(0, 5);
            b = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            wr(2'd3, d);
            if ($urandom_range(0, 2) == 0) m_clear({28'd0, 4'($urandom) & 4'hD});
            rx_send(b, stop, eff_per(d));
            chk_rd($sformatf("rnd_rx%0d_status", n), 2'd1, {28'd0, m_fe, m_ovr, 1'b0, m_valid});
            chk_rd($sformatf("rnd_rx%0d_data", n), 2'd0, {24'd0, m_byte});
            check($sformatf("rnd_rx%0d_irq", n), {31'd0, InterruptRequest}, {31'd0, m_valid});
        end

        // Loopback configuration
        m_clear(32'hD);
`ifdef UART_LOOPBACK_EN
        wr(2'd2, 32'h4);
        wr(2'd3, 32'h3);
        wr(2'd0, 32'h5A);
        repeat (50) @(negedge clk);
        chk_rd("lb_status", 2'd1, 32'h1);
        chk_rd("lb_data", 2'd0, 32'h5A);
        chk_rd("lb_ctrl", 2'd2, 32'h4);
`else
        wr(2'd2, 32'h4);
        chk_rd("nolb_ctrl", 2'd2, 32'h0);
        wr(2'd3, 32'h3);
        wr(2'd0, 32'h5A);
        repeat (50) @(negedge clk);
        chk_rd("nolb_status", 2'd1, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
